// File: rtl/crt_mask_pkg.sv
// Shared constants for the CRT shadow-mask block: command opcodes, LUT entry layout, pipeline depth.
package crt_mask_pkg;

    localparam int LATENCY = 5;

    localparam logic [2:0] OP_CTRL = 3'b000;
    localparam logic [2:0] OP_VMAX = 3'b001;
    localparam logic [2:0] OP_HMAX = 3'b010;
    localparam logic [2:0] OP_LUT  = 3'b011;

    typedef struct packed {
        logic en;
        logic rot;
        logic x2;
    } flags_t;

    // Entry layout, MSB first: {sel R, sel G, sel B, high[FRAC], low[FRAC]}
    function automatic int lut_sel_lsb(input int frac);
        return 2 * frac;
    endfunction

    function automatic int lut_high_lsb(input int frac);
        return frac;
    endfunction

    function automatic int lut_w(input int frac);
        return 2 * frac + 3;
    endfunction

endpackage

// File: rtl/crt_mask_mul.sv
// One colour channel: pixel times 1.FRAC multiplier, truncated, saturated to full scale.
module crt_mask_mul #(
    parameter int CW   = 8,
    parameter int FRAC = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] pix,
    input  logic [FRAC:0] mul,
    output logic [CW-1:0] prod
);

    logic [CW+FRAC:0] prod_p0;
    logic             unused_frac_bits;

    function automatic logic [CW-1:0] sat(input logic [CW:0] v);
        return v[CW] ? {CW{1'b1}} : v[CW-1:0];
    endfunction

    // Stage p0: full-precision product
    always_ff @(posedge clk) begin
        prod_p0 <= {{(FRAC+1){1'b0}}, pix} * {{CW{1'b0}}, mul};
    end

    // Stage p1: drop fraction, clamp
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prod <= '0;
        else        prod <= sat(prod_p0[CW+FRAC:FRAC]);
    end

    assign unused_frac_bits = ^prod_p0[FRAC-1:0];

endmodule

// File: rtl/crt_mask_v2.sv
// CRT shadow-mask overlay: per-position RGB multipliers from a double-buffered LUT,
// with frame-synchronous commit of geometry, flags and LUT bank.
module crt_mask_v2
    import crt_mask_pkg::*;
#(
    parameter int CW   = 8,
    parameter int MW   = 5,
    parameter int FRAC = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_wr,
    input  logic [15:0]   cmd_in,
    output logic          cmd_ready,
    input  logic          enable,
    input  logic [3*CW-1:0] din,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          de_in,
    output logic [3*CW-1:0] dout,
    output logic          hs_out,
    output logic          vs_out,
    output logic          de_out
);

    localparam int AW      = 2 * MW;
    localparam int DEPTH   = 1 << AW;
    localparam int EW      = lut_w(FRAC);
    localparam int SEL_LSB = lut_sel_lsb(FRAC);
    localparam int HI_LSB  = lut_high_lsb(FRAC);

    logic          rst_n;
    logic [1:0]    rst_sync;
    flags_t        sh_flags, act_flags, use_flags;
    logic [MW-1:0] sh_hmax, sh_vmax, act_hmax, act_vmax, use_hmax, use_vmax;
    logic          act_bank, use_bank, pending;
    logic          hs_q, vs_q, hs_fall, vs_fall, swap, cmd_acc, mask_en;
    logic [2:0]    opcode;
    logic [AW-1:0] wr_idx;
    logic [MW:0]   hcnt, vcnt, hcnt_cur, vcnt_cur, hmax_eff, vmax_eff;
    logic [MW-1:0] hidx, vidx;
    logic [AW:0]   raddr;
    logic          unused_cmd_bits;

    logic [EW-1:0] lut_mem [2*DEPTH];

    logic [3*CW-1:0] din_p0, din_p1, din_p2;
    logic [AW:0]     raddr_p0;
    logic            en_p0, en_p1;
    logic [EW-1:0]   lut_p1;
    logic [FRAC:0]   mul_p2 [3];
    logic [2:0]      sync_p [LATENCY];

    function automatic logic [MW:0] max_eff(input logic [MW-1:0] m, input logic x2);
        return x2 ? {m, 1'b1} : {1'b0, m};
    endfunction

    function automatic logic [MW-1:0] axis_idx(input logic [MW:0] c, input logic x2);
        return x2 ? c[MW:1] : c[MW-1:0];
    endfunction

    function automatic logic [FRAC:0] chan_mul(input logic [EW-1:0] e, input int ch, input logic en);
        if (!en)               return {1'b1, {FRAC{1'b0}}};
        if (e[SEL_LSB + ch])   return {1'b1, e[HI_LSB +: FRAC]};
        return {1'b0, e[FRAC-1:0]};
    endfunction

    // Reset asserts asynchronously, releases on a clock edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign opcode          = cmd_in[15:13];
    assign cmd_acc         = cmd_wr && !pending;
    assign cmd_ready       = !pending;
    assign hs_fall         = hs_q && !hs_in;
    assign vs_fall         = vs_q && !vs_in;
    assign swap            = pending && vs_fall;
    assign unused_cmd_bits = ^cmd_in[12:0];

    // The swap-cycle pixel already sees the incoming configuration
    always_comb begin
        use_flags = swap ? sh_flags : act_flags;
        use_hmax  = swap ? sh_hmax  : act_hmax;
        use_vmax  = swap ? sh_vmax  : act_vmax;
        use_bank  = swap ? !act_bank : act_bank;
        hmax_eff  = max_eff(use_flags.rot ? use_vmax : use_hmax, use_flags.x2);
        vmax_eff  = max_eff(use_flags.rot ? use_hmax : use_vmax, use_flags.x2);

        if (hs_fall || hcnt >= hmax_eff) hcnt_cur = '0;
        else                             hcnt_cur = hcnt + 1'b1;

        vcnt_cur = vcnt;
        if (vs_fall)                     vcnt_cur = '0;
        else if (hs_fall)                vcnt_cur = (vcnt >= vmax_eff) ? '0 : vcnt + 1'b1;

        hidx    = axis_idx(hcnt_cur, use_flags.x2);
        vidx    = axis_idx(vcnt_cur, use_flags.x2);
        raddr   = use_flags.rot ? {use_bank, hidx, vidx} : {use_bank, vidx, hidx};
        mask_en = enable && use_flags.en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_flags  <= '0;
            act_flags <= '0;
            sh_hmax   <= '0;
            sh_vmax   <= '0;
            act_hmax  <= '0;
            act_vmax  <= '0;
            act_bank  <= 1'b0;
            pending   <= 1'b0;
            wr_idx    <= '0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            hcnt      <= '0;
            vcnt      <= '0;
        end else begin
            hs_q <= hs_in;
            vs_q <= vs_in;
            hcnt <= hcnt_cur;
            vcnt <= vcnt_cur;
            if (swap) begin
                act_flags <= sh_flags;
                act_hmax  <= sh_hmax;
                act_vmax  <= sh_vmax;
                act_bank  <= !act_bank;
                pending   <= 1'b0;
            end
            if (cmd_acc) begin
                case (opcode)
                    OP_CTRL: begin
                        sh_flags <= flags_t'(cmd_in[3:1]);
                        wr_idx   <= '0;
                        if (cmd_in[0]) pending <= 1'b1;
                    end
                    OP_VMAX: sh_vmax <= cmd_in[MW-1:0];
                    OP_HMAX: sh_hmax <= cmd_in[MW-1:0];
                    OP_LUT:  wr_idx  <= wr_idx + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_acc && opcode == OP_LUT) lut_mem[{!act_bank, wr_idx}] <= cmd_in[EW-1:0];
    end

    // Stage p0: capture pixel and LUT address; p1: LUT read; p2: multipliers
    always_ff @(posedge clk) begin
        din_p0   <= din;
        raddr_p0 <= raddr;
        en_p0    <= mask_en;
        lut_p1   <= lut_mem[raddr_p0];
        din_p1   <= din_p0;
        en_p1    <= en_p0;
        din_p2   <= din_p1;
        for (int ch = 0; ch < 3; ch++) mul_p2[ch] <= chan_mul(lut_p1, ch, en_p1);
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        crt_mask_mul #(.CW(CW), .FRAC(FRAC)) u_mul (
            .clk  (clk),
            .rst_n(rst_n),
            .pix  (din_p2[ch*CW +: CW]),
            .mul  (mul_p2[ch]),
            .prod (dout[ch*CW +: CW])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) sync_p[i] <= '0;
        end else begin
            sync_p[0] <= {hs_in, vs_in, de_in};
            for (int i = 1; i < LATENCY; i++) sync_p[i] <= sync_p[i-1];
        end
    end

    assign {hs_out, vs_out, de_out} = sync_p[LATENCY-1];

endmodule

// File: tb/tb_crt_mask_v2.sv
// Directed bench for crt_mask_v2: pass-through, LUT masking, commit/swap timing, 2x+rotate geometry, reset.
module tb_crt_mask_v2;

    logic        clk = 1'b0;
    logic        reset_n, cmd_wr, cmd_ready, enable;
    logic [15:0] cmd_in;
    logic [23:0] din, dout;
    logic        hs_in, vs_in, de_in, hs_out, vs_out, de_out;
    int          checks = 0;
    int          failures = 0;
    int          step_id = 0;

    typedef struct packed {
        logic        chk;
        int          id;
        logic [23:0] px;
        logic        hs;
        logic        vs;
        logic        de;
    } exp_t;

    exp_t pipe [5];

    always #5 clk = ~clk;

    crt_mask_v2 #(.CW(8), .MW(5), .FRAC(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_wr   (cmd_wr),
        .cmd_in   (cmd_in),
        .cmd_ready(cmd_ready),
        .enable   (enable),
        .din      (din),
        .hs_in    (hs_in),
        .vs_in    (vs_in),
        .de_in    (de_in),
        .dout     (dout),
        .hs_out   (hs_out),
        .vs_out   (vs_out),
        .de_out   (de_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_pipe();
        for (int i = 0; i < 5; i++) pipe[i] = '0;
    endtask

    // Output of the pixel driven five steps ago is due right after this edge
    task automatic step(input logic [23:0] px, input logic hs, input logic vs, input logic de,
                        input logic chk, input logic [23:0] ex);
        @(posedge clk);
        #1;
        if (pipe[4].chk) begin
            check($sformatf("dout#%0d", pipe[4].id), {8'h0, dout}, {8'h0, pipe[4].px});
            check($sformatf("syncs#%0d", pipe[4].id), {29'h0, hs_out, vs_out, de_out},
                  {29'h0, pipe[4].hs, pipe[4].vs, pipe[4].de});
        end
        for (int i = 4; i > 0; i--) pipe[i] = pipe[i-1];
        step_id++;
        pipe[0] = '{chk: chk, id: step_id, px: ex, hs: hs, vs: vs, de: de};
        din   = px;
        hs_in = hs;
        vs_in = vs;
        de_in = de;
    endtask

    task automatic idle();
        step(24'h0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) idle();
    endtask

    task automatic cmd(input logic [15:0] w);
        cmd_in = w;
        cmd_wr = 1'b1;
        idle();
        cmd_wr = 1'b0;
    endtask

    task automatic pix(input logic [23:0] px, input logic [23:0] ex);
        step(px, 1'b0, 1'b0, 1'b1, 1'b1, ex);
    endtask

    task automatic frame_start(input logic [23:0] px, input logic [23:0] ex);
        step(24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        step(px, 1'b0, 1'b0, 1'b1, 1'b1, ex);
    endtask

    task automatic line_start(input logic [23:0] px, input logic [23:0] ex);
        step(24'h0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0);
        step(px, 1'b0, 1'b0, 1'b1, 1'b1, ex);
    endtask

    initial begin
        clear_pipe();
        reset_n = 1'b0;
        cmd_wr  = 1'b0;
        cmd_in  = 16'h0;
        enable  = 1'b1;
        din     = 24'h0;
        hs_in   = 1'b0;
        vs_in   = 1'b0;
        de_in   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", {8'h0, dout}, 32'h0);
        check("rst_syncs", {29'h0, hs_out, vs_out, de_out}, 32'h0);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);

        reset_n = 1'b1;
        repeat (4) idle();

        // Nothing committed: mask inactive, pixels and syncs pass unchanged
        step(24'h804020, 1'b1, 1'b1, 1'b1, 1'b1, 24'h804020);
        step(24'h123456, 1'b0, 1'b1, 1'b0, 1'b1, 24'h123456);
        step(24'hABCDEF, 1'b1, 1'b0, 1'b1, 1'b1, 24'hABCDEF);
        step(24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 24'h000000);
        drain();

        // hmax=2, vmax=0, three-entry stripe pattern, enable + commit
        cmd(16'h0000);
        cmd(16'h2000);
        cmd(16'h4002);
        cmd(16'h6484);
        cmd(16'h6284);
        cmd(16'h6184);
        cmd(16'h0009);
        check("pending_ready", {31'h0, cmd_ready}, 32'h0);
        cmd(16'h4000);
        check("still_pending", {31'h0, cmd_ready}, 32'h0);
        pix(24'h112233, 24'h112233);
        pix(24'h445566, 24'h445566);
        frame_start(24'hFFFFFF, 24'hFF3F3F);
        pix(24'hFFFFFF, 24'h3FFF3F);
        check("ready_after_swap", {31'h0, cmd_ready}, 32'h1);
        pix(24'hFFFFFF, 24'h3F3FFF);
        pix(24'hFFFFFF, 24'hFF3F3F);
        pix(24'hFFFFFF, 24'h3FFF3F);
        pix(24'hFFFFFF, 24'h3F3FFF);
        pix(24'hC0C0C0, 24'hFF3030);
        pix(24'h40C080, 24'h10FF20);
        pix(24'h102030, 24'h040848);

        // Commit landing on the vs-fall cycle waits for the next frame
        frame_start(24'hFFFFFF, 24'hFF3F3F);
        cmd_in = 16'h0001;
        cmd_wr = 1'b1;
        pix(24'hFFFFFF, 24'h3FFF3F);
        cmd_wr = 1'b0;
        check("late_commit_pending", {31'h0, cmd_ready}, 32'h0);
        pix(24'hFFFFFF, 24'h3F3FFF);
        frame_start(24'hABCDEF, 24'hABCDEF);
        pix(24'h13579B, 24'h13579B);
        check("late_commit_done", {31'h0, cmd_ready}, 32'h1);
        drain();

        // 2x + rotate, hmax=1, vmax=3: only LUT address 0 boosts red
        cmd(16'h0000);
        cmd(16'h4001);
        cmd(16'h2003);
        for (int i = 0; i < 98; i++) cmd((i == 0) ? 16'h6484 : 16'h6004);
        cmd(16'h000F);
        frame_start(24'hFFFFFF, 24'hFF3F3F);
        for (int k = 1; k < 10; k++) pix(24'hFFFFFF, ((k % 8) < 2) ? 24'hFF3F3F : 24'h3F3F3F);
        line_start(24'hFFFFFF, 24'hFF3F3F);
        line_start(24'hFFFFFF, 24'h3F3F3F);
        line_start(24'hFFFFFF, 24'h3F3F3F);
        line_start(24'hFFFFFF, 24'hFF3F3F);
        line_start(24'hFFFFFF, 24'hFF3F3F);
        line_start(24'hFFFFFF, 24'h3F3F3F);
        frame_start(24'hFFFFFF, 24'hFF3F3F);
        drain();

        // Reset while a commit is pending, with live data in the pipe
        cmd(16'h0001);
        check("pre_reset_pending", {31'h0, cmd_ready}, 32'h0);
        for (int i = 0; i < 6; i++) step(24'hFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0);
        reset_n = 1'b0;
        #1;
        clear_pipe();
        check("async_rst_dout", {8'h0, dout}, 32'h0);
        check("async_rst_syncs", {29'h0, hs_out, vs_out, de_out}, 32'h0);
        check("async_rst_ready", {31'h0, cmd_ready}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) idle();
        pix(24'h5A5A5A, 24'h5A5A5A);
        frame_start(24'hFFFFFF, 24'hFFFFFF);
        pix(24'hC0C0C0, 24'hC0C0C0);
        check("post_reset_ready", {31'h0, cmd_ready}, 32'h1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
